// File: rtl/voice_match.sv
// Voice template matcher: sweeps five RAMs in lockstep and accumulates the Hamming
// distance of the sample against four templates, then reports the closest one.
`timescale 1ns/1ps
module voice_match #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH+$clog2(DATA_WIDTH):0] THRESH = '1
) (
  input  logic                                    clk,
  input  logic                                    reset_L,
  input  logic                                    start,
  output logic [ADDR_WIDTH-1:0]                   ram_addr,
  input  logic [DATA_WIDTH-1:0]                   sample_in,
  input  logic [DATA_WIDTH-1:0]                   up_in,
  input  logic [DATA_WIDTH-1:0]                   down_in,
  input  logic [DATA_WIDTH-1:0]                   left_in,
  input  logic [DATA_WIDTH-1:0]                   right_in,
  output logic                                    busy,
  output logic [1:0]                              match,
  output logic [ADDR_WIDTH+$clog2(DATA_WIDTH):0]  min_dist,
  output logic                                    reject,
  output logic                                    match_valid
);

  localparam int DIST_W = ADDR_WIDTH + $clog2(DATA_WIDTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    DRAIN,
    COMPARE,
    DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DIST_W-1:0]       r_acc [4];
  logic [DATA_WIDTH-1:0]   w_tmpl [4];
  logic                    w_last;
  logic                    w_acc_en;
  logic                    w_start_ok;
  logic                    w_busy;
  logic [1:0]              w_best_idx;
  logic [DIST_W-1:0]       w_best_dist;
  logic [1:0]              r_match;
  logic [DIST_W-1:0]       r_min_dist;
  logic                    r_reject;
  logic                    r_valid;

  function automatic logic [DIST_W-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      c = c + DIST_W'(v[i]);
    end
    return c;
  endfunction

  assign w_tmpl[0] = up_in;
  assign w_tmpl[1] = down_in;
  assign w_tmpl[2] = left_in;
  assign w_tmpl[3] = right_in;

  assign w_last     = (r_addr == LAST_ADDR);
  assign w_start_ok = (r_state == IDLE) && start;
  // Read data lags the address by one cycle, so the word for address k-1
  // arrives while address k is presented; DRAIN collects the final word.
  assign w_acc_en   = ((r_state == SWEEP) && (r_addr != '0)) || (r_state == DRAIN);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SWEEP;
        end
      end
      SWEEP: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        w_next = COMPARE;
      end
      COMPARE: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_addr <= '0;
    end else if ((r_state == SWEEP) && !w_last) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
    end else begin
      r_addr <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_start_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_acc_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= r_acc[i] + popcnt(sample_in ^ w_tmpl[i]);
      end
    end
  end

  // Strict less-than scanning upward keeps ties on the lowest template code.
  always_comb begin
    w_best_idx  = 2'd0;
    w_best_dist = r_acc[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (r_acc[i] < w_best_dist) begin
        w_best_dist = r_acc[i];
        w_best_idx  = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_match    <= '0;
      r_min_dist <= '0;
      r_reject   <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= (r_state == COMPARE);
      if (r_state == COMPARE) begin
        r_match    <= w_best_idx;
        r_min_dist <= w_best_dist;
        r_reject   <= (w_best_dist > THRESH);
      end
    end
  end

  assign ram_addr    = r_addr;
  assign busy        = w_busy;
  assign match       = r_match;
  assign min_dist    = r_min_dist;
  assign reject      = r_reject;
  assign match_valid = r_valid;

endmodule

// File: tb/tb_voice_match.sv
// Scoreboard bench for voice_match: directed RAM images with hand-computed
// expected template, distance, reject flag and result latency.
`timescale 1ns/1ps
module tb_voice_match;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int NW    = 8;
  localparam int DISTW = AW + $clog2(DW) + 1;

  logic             clk = 1'b0;
  logic             reset_L = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    sample_in = '0;
  logic [DW-1:0]    up_in = '0;
  logic [DW-1:0]    down_in = '0;
  logic [DW-1:0]    left_in = '0;
  logic [DW-1:0]    right_in = '0;
  logic             busy;
  logic [1:0]       match;
  logic [DISTW-1:0] min_dist;
  logic             reject;
  logic             match_valid;

  logic [DW-1:0] m_s [NW];
  logic [DW-1:0] m_u [NW];
  logic [DW-1:0] m_d [NW];
  logic [DW-1:0] m_l [NW];
  logic [DW-1:0] m_r [NW];

  typedef struct {
    logic [1:0]       m;
    logic [DISTW-1:0] d;
    logic             r;
    int               e0;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   n_kicks  = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  voice_match #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .THRESH     (9'd10)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .start       (start),
    .ram_addr    (ram_addr),
    .sample_in   (sample_in),
    .up_in       (up_in),
    .down_in     (down_in),
    .left_in     (left_in),
    .right_in    (right_in),
    .busy        (busy),
    .match       (match),
    .min_dist    (min_dist),
    .reject      (reject),
    .match_valid (match_valid)
  );

  // Five synchronous RAMs with one-cycle read latency
  always @(posedge clk) begin
    sample_in <= m_s[ram_addr];
    up_in     <= m_u[ram_addr];
    down_in   <= m_d[ram_addr];
    left_in   <= m_l[ram_addr];
    right_in  <= m_r[ram_addr];
    cyc       <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (match_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_match_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("match", 64'(match), 64'(e.m));
        check("min_dist", 64'(min_dist), 64'(e.d));
        check("reject", 64'(reject), 64'(e.r));
        check("latency", 64'(cyc - e.e0), 64'(NW + 2));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NW; i++) begin
      m_s[i] = '0;
      m_u[i] = '0;
      m_d[i] = '0;
      m_l[i] = '0;
      m_r[i] = '0;
    end
  endtask

  task automatic load_down_exact();
    for (int i = 0; i < NW; i++) begin
      m_s[i] = 32'hA5A5_0000 + 32'(i * 37);
      m_d[i] = m_s[i];
      m_u[i] = m_s[i] ^ 32'h0000_0001;
      m_l[i] = m_s[i] ^ 32'h0000_0010;
      m_r[i] = m_s[i] ^ 32'h8000_0000;
    end
  endtask

  // Returns at the falling edge inside the first SWEEP cycle
  task automatic pulse_start(output int e0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic kick(input logic [1:0] m, input int d, input logic r);
    exp_t e;
    int   e0;
    pulse_start(e0);
    check("busy_in_sweep", 64'(busy), 1);
    e.m  = m;
    e.d  = DISTW'(d);
    e.r  = r;
    e.e0 = e0;
    sb.push_back(e);
    n_kicks++;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (match_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_timeout", 64'(seen), 1);
    if (seen) begin
      check("busy_in_done", 64'(busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int e0;
    int v_before;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_ram_addr", 64'(ram_addr), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_match_valid", 64'(match_valid), 0);
    check("rst_match", 64'(match), 0);
    check("rst_min_dist", 64'(min_dist), 0);
    check("rst_reject", 64'(reject), 0);
    reset_L = 1'b1;
    repeat (2) @(negedge clk);

    // Sample equals the down template; the others differ by one bit per word
    load_down_exact();
    kick(2'b01, 0, 1'b0);
    wait_valid();
    repeat (3) @(negedge clk);
    check("hold_match", 64'(match), 1);
    check("hold_min_dist", 64'(min_dist), 0);
    check("idle_busy", 64'(busy), 0);

    // Four identical templates, 5 bits away in total: tie resolves to up
    clear_mem();
    for (int i = 0; i < NW; i++) begin
      if (i == 3) begin
        m_u[i] = 32'h0000_1F00;
        m_d[i] = 32'h0000_1F00;
        m_l[i] = 32'h0000_1F00;
        m_r[i] = 32'h0000_1F00;
      end
    end
    kick(2'b00, 5, 1'b0);
    wait_valid();

    // Maximum distance 8*32 = 256 must not wrap
    clear_mem();
    for (int i = 0; i < NW; i++) m_s[i] = '1;
    kick(2'b00, 256, 1'b1);
    wait_valid();

    // Start re-pulsed mid-sweep and in DONE must be ignored
    clear_mem();
    for (int i = 0; i < NW; i++) begin
      m_u[i] = 32'h0000_0007;
      m_d[i] = 32'h0000_0003;
    end
    m_l[0] = 32'h0000_0001;
    m_r[5] = 32'hF000_0000;
    kick(2'b10, 1, 1'b0);
    check("sweep_addr_0", 64'(ram_addr), 0);
    for (int k = 1; k < NW; k++) begin
      @(negedge clk);
      start = (k == 3);
      check("sweep_addr", 64'(ram_addr), 64'(k));
    end
    start = 1'b0;
    @(negedge clk);
    check("drain_addr", 64'(ram_addr), 0);
    check("drain_busy", 64'(busy), 1);
    wait_valid();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", 64'(busy), 0);
    repeat (3) @(negedge clk);
    check("still_idle_busy", 64'(busy), 0);
    check("still_idle_addr", 64'(ram_addr), 0);

    // Reset in the k=4 sweep cycle aborts without a result
    load_down_exact();
    v_before = n_valid;
    pulse_start(e0);
    repeat (4) @(negedge clk);
    check("abort_k4_addr", 64'(ram_addr), 4);
    #1 reset_L = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_addr", 64'(ram_addr), 0);
    check("abort_match", 64'(match), 0);
    check("abort_min_dist", 64'(min_dist), 0);
    check("abort_valid", 64'(match_valid), 0);
    @(negedge clk);
    reset_L = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_valid", 64'(n_valid), 64'(v_before));
    kick(2'b01, 0, 1'b0);
    wait_valid();

    // Threshold 10: best 11 rejects, best 10 accepts
    clear_mem();
    m_u[0] = 32'h0000_07FF;
    m_d[0] = 32'h0000_0FFF;
    m_l[0] = 32'h000F_FFFF;
    m_r[0] = 32'h0000_1FFF;
    kick(2'b00, 11, 1'b1);
    wait_valid();
    m_r[0] = 32'h0000_03FF;
    kick(2'b11, 10, 1'b0);
    wait_valid();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 0);
    check("valid_count", 64'(n_valid), 64'(n_kicks));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_match.md
VOICE_MATCH -- requirements
Module: voice_match

Interface
REQ-001 The module SHALL have the parameter ADDR_WIDTH, default 12, meaning the RAM address width.
REQ-002 The module SHALL have the parameter DATA_WIDTH, default 32, meaning the RAM word width.
REQ-003 The module SHALL have the parameter NUM_WORDS, default 4096, meaning the words compared per sweep; legal range 1..2^ADDR_WIDTH.
REQ-004 The module SHALL have the parameter THRESH, default all ones, meaning the maximum accepted distance; DIST_W = ADDR_WIDTH+$clog2(DATA_WIDTH)+1.
REQ-005 The module SHALL have the port clk, input, 1 bit: the system clock; all logic is on its rising edge.
REQ-006 The module SHALL have the port reset_L, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The module SHALL have the port start, input, 1 bit: a request to begin one comparison sweep.
REQ-008 The module SHALL have the port ram_addr, output, ADDR_WIDTH bits: the shared read address to all five RAMs.
REQ-009 The module SHALL have the ports sample_in, up_in, down_in, left_in and right_in, each input, DATA_WIDTH bits: RAM read data with 1-cycle read latency.
REQ-010 The module SHALL have the port busy, output, 1 bit: high from the accepted start until match_valid.
REQ-011 The module SHALL have the port match, output, 2 bits: the best template, where 00=up, 01=down, 10=left and 11=right.
REQ-012 The module SHALL have the port min_dist, output, DIST_W bits: the distance of the winning template.
REQ-013 The module SHALL have the port reject, output, 1 bit: min_dist > THRESH.
REQ-014 The module SHALL have the port match_valid, output, 1 bit: a 1-cycle pulse when match, min_dist and reject are updated.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SWEEP, DRAIN, COMPARE and DONE.
REQ-016 The FSM SHALL go from IDLE to SWEEP on the edge at which start=1 is sampled (edge E0), and SHALL clear all four accumulators and the address counter on that edge.
REQ-017 In SWEEP, ram_addr SHALL equal k in the k-th SWEEP cycle, for k = 0..NUM_WORDS-1.
REQ-018 The FSM SHALL go from SWEEP to DRAIN on the edge leaving the cycle with ram_addr = NUM_WORDS-1.
REQ-019 On every edge leaving a SWEEP cycle with k>=1, and on the edge leaving DRAIN, each accumulator SHALL add popcount(sample_in XOR template_in), using the data returned for the previous address.
REQ-020 The word at address 0 SHALL be accumulated; data present during the first SWEEP cycle SHALL be ignored.
REQ-021 Accumulators SHALL be DIST_W bits wide and SHALL never overflow (maximum NUM_WORDS*DATA_WIDTH); no saturation logic is required.
REQ-022 DRAIN SHALL last exactly 1 cycle and then go to COMPARE.
REQ-023 COMPARE SHALL last exactly 1 cycle, SHALL select the minimum accumulator by strict less-than in order up, down, left, right (a tie goes to the lower code), and SHALL then go to DONE.
REQ-024 On entry to DONE, match, min_dist and reject SHALL be registered and match_valid SHALL be 1 for exactly 1 cycle; DONE SHALL then go to IDLE.
REQ-025 match_valid SHALL rise NUM_WORDS+2 cycles after edge E0.
REQ-026 busy SHALL be 1 in SWEEP, DRAIN and COMPARE, and SHALL be 0 in IDLE and DONE.
REQ-027 start SHALL be ignored in every state except IDLE; a start sampled in IDLE after DONE SHALL begin a new sweep.
REQ-028 match, min_dist and reject SHALL hold their last values until the next DONE.
REQ-029 ram_addr SHALL be 0 in IDLE, DRAIN, COMPARE and DONE.

Reset
REQ-030 While reset_L=0, the module SHALL immediately force state=IDLE, and SHALL set ram_addr, accumulators, match, min_dist, reject, match_valid and busy to 0.
REQ-031 A reset asserted mid-sweep SHALL abort the sweep with no match_valid pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-032 The bench SHALL cover: NUM_WORDS=8, sample equal to the down template, other templates differing in 1 bit per word -> match=01, min_dist=0, reject=0, match_valid exactly 10 cycles after E0.
REQ-033 The bench SHALL cover: all four templates identical and 5 bits different from sample in total -> match=00, min_dist=5 (tie-break).
REQ-034 The bench SHALL cover: NUM_WORDS=8, sample all ones, all templates 0 -> min_dist=256, match=00, with no overflow.
REQ-035 The bench SHALL cover: start re-pulsed during SWEEP and during DONE -> exactly one match_valid and ram_addr sequence 0..7 unchanged.
REQ-036 The bench SHALL cover: reset_L low at k=4 of SWEEP -> busy=0 and ram_addr=0 immediately, no match_valid; then a new start gives the correct result.
REQ-037 The bench SHALL cover: THRESH=10 with best distance 11 -> reject=1 and match still the argmin; with best distance 10 -> reject=0.
